// File: rtl/botao_pkg.sv
// Shared definitions for the pushbutton conditioning block: FSM state encoding
// and default cycle counts for a 50 MHz board clock.
package botao_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        LONG_HELD,
        DEB_REL
    } estado_t;

    localparam int DEB_CYCLES_50M  = 50000;
    localparam int LONG_CYCLES_50M = 50000000;

endpackage

// File: rtl/sinc2ff.sv
// Two-flop synchronizer for an asynchronous board input; the reset value is
// supplied as an input so the idle level of each switch can be matched.
module sinc2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= rst_val;
            s2_q <= rst_val;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/cond_botao.sv
// Pushbutton conditioning: synchronizes and debounces a raw button, emits a
// one-clock pulse per short press and toggles a power level per long press.
module cond_botao
    import botao_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_50M,
    parameter int LONG_CYCLES = LONG_CYCLES_50M,
    parameter bit ATIVO_BAIXO = 1'b1,
    parameter bit LIGA_RST    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bot_bruto,
    output logic bot_pulso,
    output logic liga,
    output logic pressionado
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic bot_sinc;
    logic p;

    estado_t           state_q, state_d;
    estado_t           origem_q, origem_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              liga_q, liga_d;
    logic              bot_pulso_q, bot_pulso_d;
    logic              pressionado_q, pressionado_d;

    // Synchronizer flops reset to the released pin level.
    sinc2ff u_sinc (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val (ATIVO_BAIXO),
        .d       (bot_bruto),
        .q       (bot_sinc)
    );

    assign p = ATIVO_BAIXO ? ~bot_sinc : bot_sinc;

    always_comb begin
        state_d     = state_q;
        origem_d    = origem_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        liga_d      = liga_q;
        bot_pulso_d = 1'b0;

        case (state_q)
            IDLE: begin
                deb_cnt_d = '0;
                if (p) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            DEB_PRESS: begin
                if (!p) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    state_d    = PRESSED;
                    deb_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            PRESSED: begin
                // A release seen on the same cycle as the long threshold wins.
                if (!p) begin
                    state_d   = DEB_REL;
                    origem_d  = PRESSED;
                    deb_cnt_d = DEB_W'(1);
                end else if (hold_cnt_q >= HOLD_LAST) begin
                    state_d = LONG_HELD;
                    liga_d  = ~liga_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            LONG_HELD: begin
                if (!p) begin
                    state_d   = DEB_REL;
                    origem_d  = LONG_HELD;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            DEB_REL: begin
                // Bounce during release resumes the origin state without touching hold_cnt.
                if (p) begin
                    state_d   = origem_q;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    state_d     = IDLE;
                    deb_cnt_d   = '0;
                    bot_pulso_d = (origem_q == PRESSED);
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase

        pressionado_d = (state_d == PRESSED) || (state_d == LONG_HELD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            origem_q      <= IDLE;
            deb_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            liga_q        <= LIGA_RST;
            bot_pulso_q   <= 1'b0;
            pressionado_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            origem_q      <= origem_d;
            deb_cnt_q     <= deb_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            liga_q        <= liga_d;
            bot_pulso_q   <= bot_pulso_d;
            pressionado_q <= pressionado_d;
        end
    end

    assign bot_pulso   = bot_pulso_q;
    assign liga        = liga_q;
    assign pressionado = pressionado_q;

endmodule

// File: tb/tb_cond_botao.sv
// Directed bench for cond_botao with short debounce/long-press counts.
module tb_cond_botao;
    import botao_pkg::*;

    logic clk;
    logic rst_n;
    logic bot_bruto;
    logic bot_pulso;
    logic liga;
    logic pressionado;

    int nchk;
    int nerr;

    int pulse_tot;
    int press_tot;
    int liga_chg_tot;
    int pulse_consec;
    logic liga_prev;
    logic pulso_prev;

    int p0;
    int q0;
    int l0;

    cond_botao #(
        .DEB_CYCLES  (4),
        .LONG_CYCLES (20),
        .ATIVO_BAIXO (1'b1),
        .LIGA_RST    (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bot_bruto   (bot_bruto),
        .bot_pulso   (bot_pulso),
        .liga        (liga),
        .pressionado (pressionado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitors sampled on the inactive edge.
    initial begin
        pulse_tot    = 0;
        press_tot    = 0;
        liga_chg_tot = 0;
        pulse_consec = 0;
        liga_prev    = 1'b0;
        pulso_prev   = 1'b0;
    end

    always @(negedge clk) begin
        if (bot_pulso === 1'b1) pulse_tot = pulse_tot + 1;
        if (bot_pulso === 1'b1 && pulso_prev === 1'b1) pulse_consec = pulse_consec + 1;
        if (pressionado === 1'b1) press_tot = press_tot + 1;
        if (liga !== liga_prev) liga_chg_tot = liga_chg_tot + 1;
        liga_prev  = liga;
        pulso_prev = bot_pulso;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk = nchk + 1;
        assert (obs === exp) else begin
            nerr = nerr + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        nchk      = 0;
        nerr      = 0;
        rst_n     = 1'b0;
        bot_bruto = 1'b1;

        cyc(3);
        chk("rst_liga", {31'b0, liga}, 0);
        chk("rst_pulso", {31'b0, bot_pulso}, 0);
        chk("rst_press", {31'b0, pressionado}, 0);
        rst_n = 1'b1;
        cyc(3);

        // Clean short press: 10 clk low, then release.
        p0 = pulse_tot;
        l0 = liga_chg_tot;
        bot_bruto = 1'b0;
        cyc(5);
        chk("short_press_at5", {31'b0, pressionado}, 0);
        cyc(1);
        chk("short_press_at6", {31'b0, pressionado}, 1);
        cyc(4);
        bot_bruto = 1'b1;
        cyc(5);
        chk("short_pulso_at5", {31'b0, bot_pulso}, 0);
        chk("short_press_rel", {31'b0, pressionado}, 0);
        cyc(1);
        chk("short_pulso_at6", {31'b0, bot_pulso}, 1);
        cyc(1);
        chk("short_pulso_at7", {31'b0, bot_pulso}, 0);
        cyc(4);
        chk("short_npulse", pulse_tot - p0, 1);
        chk("short_liga", {31'b0, liga}, 0);
        chk("short_liga_chg", liga_chg_tot - l0, 0);

        // Bouncy press.
        p0 = pulse_tot;
        for (int i = 0; i < 6; i++) begin
            bot_bruto = (i % 2 == 0) ? 1'b0 : 1'b1;
            cyc(1);
        end
        bot_bruto = 1'b0;
        cyc(10);
        bot_bruto = 1'b1;
        cyc(12);
        chk("bouncy_npulse", pulse_tot - p0, 1);
        chk("bouncy_liga", {31'b0, liga}, 0);
        chk("bouncy_press_end", {31'b0, pressionado}, 0);

        // Glitch of 3 clk, one short of the debounce count.
        p0 = pulse_tot;
        q0 = press_tot;
        bot_bruto = 1'b0;
        cyc(3);
        bot_bruto = 1'b1;
        cyc(10);
        chk("glitch_npress", press_tot - q0, 0);
        chk("glitch_npulse", pulse_tot - p0, 0);

        // First long press: liga 0 -> 1, 20 clk after pressionado rises.
        p0 = pulse_tot;
        l0 = liga_chg_tot;
        bot_bruto = 1'b0;
        cyc(6);
        chk("long1_press", {31'b0, pressionado}, 1);
        chk("long1_liga_start", {31'b0, liga}, 0);
        cyc(19);
        chk("long1_liga_at19", {31'b0, liga}, 0);
        cyc(1);
        chk("long1_liga_at20", {31'b0, liga}, 1);
        cyc(14);
        bot_bruto = 1'b1;
        cyc(12);
        chk("long1_liga_end", {31'b0, liga}, 1);
        chk("long1_liga_chg", liga_chg_tot - l0, 1);
        chk("long1_npulse", pulse_tot - p0, 0);
        chk("long1_press_end", {31'b0, pressionado}, 0);

        // Second long press: liga back to 0.
        p0 = pulse_tot;
        l0 = liga_chg_tot;
        bot_bruto = 1'b0;
        cyc(40);
        bot_bruto = 1'b1;
        cyc(12);
        chk("long2_liga", {31'b0, liga}, 0);
        chk("long2_liga_chg", liga_chg_tot - l0, 1);
        chk("long2_npulse", pulse_tot - p0, 0);

        // Long press with bounce during release.
        p0 = pulse_tot;
        l0 = liga_chg_tot;
        bot_bruto = 1'b0;
        cyc(30);
        chk("lbounce_liga_held", {31'b0, liga}, 1);
        bot_bruto = 1'b1;
        cyc(2);
        bot_bruto = 1'b0;
        cyc(1);
        bot_bruto = 1'b1;
        cyc(12);
        chk("lbounce_liga_chg", liga_chg_tot - l0, 1);
        chk("lbounce_npulse", pulse_tot - p0, 0);
        chk("lbounce_press_end", {31'b0, pressionado}, 0);
        chk("lbounce_idle", {29'b0, dut.state_q}, {29'b0, IDLE});

        chk("no_consec_pulse", pulse_consec, 0);

        // Asynchronous reset mid-press, then re-debounce of the held button.
        bot_bruto = 1'b0;
        cyc(8);
        chk("mid_press_before_rst", {31'b0, pressionado}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_liga", {31'b0, liga}, 0);
        chk("async_rst_pulso", {31'b0, bot_pulso}, 0);
        chk("async_rst_press", {31'b0, pressionado}, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        chk("rst_redeb_at5", {31'b0, pressionado}, 0);
        cyc(1);
        chk("rst_redeb_at6", {31'b0, pressionado}, 1);
        bot_bruto = 1'b1;
        cyc(10);
        chk("rst_redeb_release", {31'b0, pressionado}, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/cond_botao.md
Name: cond_botao

Overview:
- Input-conditioning stage directly upstream of the stopwatch/display top.
- Takes one raw mechanical pushbutton and generates both of that top's control inputs:
  - a one-clock short-press pulse for `bot`;
  - a power level for `on_liga`, toggled by a long press.
- Replaces the loose wiring of a raw switch to `on_liga`.
- Structural/behavioural RTL: synchronizer, debounce counter, hold counter and a 5-state FSM.

Parameters:
- DEB_CYCLES, 50000, consecutive stable clk samples needed to accept a press or release (1 ms at 50 MHz).
- LONG_CYCLES, 50000000, clk cycles a debounced press must be held to count as long (1 s at 50 MHz).
- ATIVO_BAIXO, 1, 1 = button reads 0 when pressed (board pushbuttons); 0 = reads 1 when pressed.
- LIGA_RST, 0, value of `liga` after reset.

Ports:
- clk  input  1  system clock (50 MHz board clock).
- rst_n  input  1  asynchronous active-low reset.
- bot_bruto  input  1  raw asynchronous pushbutton.
- bot_pulso  output  1  one-clk pulse per accepted short press; drives `bot` downstream.
- liga  output  1  power level, toggled per accepted long press; drives `on_liga` downstream.
- pressionado  output  1  debounced button level; 1 while in PRESSED or LONG_HELD.

Behaviour:
- Reset (rst_n=0, async):
  - sync FFs = released level;
  - FSM = IDLE;
  - both counters = 0;
  - bot_pulso = 0, pressionado = 0, liga = LIGA_RST.
  - Reset deasserted mid-press: the FSM restarts from IDLE, so a still-held button must re-debounce.
- Input path:
  - 2-FF synchronizer on bot_bruto, then polarity normalisation to `p` (1 = pressed).
  - `p` lags the pin by 2 clk.
- Counter widths:
  - deb_cnt is $clog2(DEB_CYCLES+1) bits.
  - hold_cnt is $clog2(LONG_CYCLES+1) bits.
  - Both saturate and never wrap.
- FSM states: IDLE, DEB_PRESS, PRESSED, LONG_HELD, DEB_REL.
- IDLE:
  - deb_cnt = 0.
  - p=1 → DEB_PRESS with deb_cnt = 1.
- DEB_PRESS:
  - p=0 → IDLE (glitch rejected, no output).
  - p=1 → deb_cnt++.
  - When deb_cnt reaches DEB_CYCLES → PRESSED, with hold_cnt = 0 and deb_cnt = 0.
- PRESSED:
  - hold_cnt++ each clk.
  - When hold_cnt reaches LONG_CYCLES-1 with p=1 → LONG_HELD and liga toggles on the same edge.
  - p=0 → DEB_REL, with origem = PRESSED and deb_cnt = 1.
  - If both events fall on the same cycle, the release wins: no toggle, go to DEB_REL.
- LONG_HELD:
  - hold_cnt is frozen and there is no further toggle, however long the button is held.
  - p=0 → DEB_REL with origem = LONG_HELD.
- DEB_REL:
  - p=1 → return to origem, with hold_cnt unchanged (bounce during release does not restart the hold timer).
  - p=0 → deb_cnt++.
  - When deb_cnt reaches DEB_CYCLES → IDLE.
  - bot_pulso = 1 for exactly that one clk, and only if origem = PRESSED.
- Output timing:
  - bot_pulso and liga are registered (Moore/registered outputs).
  - bot_pulso is never asserted on two consecutive clks.
  - Minimum latency from a clean release edge at the pin to bot_pulso high: 2 + DEB_CYCLES clk.
  - pressionado is registered and decoded from state.
  - On a clean press, liga toggles LONG_CYCLES clk after pressionado rises.
- Gating:
  - liga=0 does not suppress bot_pulso.
  - Gating by `on_liga` is the downstream block's job.

Decomposition:
- Shared package `botao_pkg`:
  - state enum (IDLE, DEB_PRESS, PRESSED, LONG_HELD, DEB_REL);
  - default cycle constants for 50 MHz.
- One natural sub-module: `sinc2ff`, a 2-flop synchronizer with reset value input, reusable for other board switches.
- Everything else stays in cond_botao.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=20, ATIVO_BAIXO=1):
- Reset check: assert rst_n=0 mid-simulation → liga=0, bot_pulso=0 and pressionado=0 immediately, without waiting for a clock edge.
- Clean short press: bot_bruto=0 for 10 clk, then 1 → pressionado rises at clk 6 after the press, and there is exactly one bot_pulso 6 clk after release; liga stays 0.
- Bouncy press: bot_bruto toggles 0/1 every clk for 6 clk, then holds 0 for 10 clk and releases → one bot_pulso and no spurious pulse from the bounce.
- Glitch rejection: 3-clk low glitch (shorter than DEB_CYCLES) → no pressionado, no bot_pulso.
- Long press: hold for 40 clk → liga goes 0→1 exactly once, 20 clk after pressionado rises, and no bot_pulso on release. A second 40-clk hold → liga goes back to 0.
- Release bounce during a long press: hold 30 clk, bounce 2 clk high/1 low, then release → no extra toggle, no bot_pulso, FSM ends in IDLE.
